// File: rtl/musb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | musb_pkg: shared encodings for the hazard unit and mult/div sequencer|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package musb_pkg;

  localparam logic [1:0] FWD_GPR = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  localparam int SEQ_CNT_W = 6;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_BUSY = 2'd1,
    SEQ_DONE = 2'd2
  } seq_state_t;

  // $0 is hardwired, so a producer writing it never creates a dependency.
  function automatic logic reg_match(input logic       uses,
                                     input logic [4:0] r,
                                     input logic       we,
                                     input logic [4:0] wa);
    return uses && (r != 5'd0) && we && (wa == r);
  endfunction

endpackage
`default_nettype wire

// File: rtl/musb_muldiv_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | musb_muldiv_sequencer: holds EX for DIV_CYCLES cycles per mult/div   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module musb_muldiv_sequencer
  import musb_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic hold,
  input  logic abort,
  output logic busy,
  output logic done,
  output logic seq_hold
);

  localparam logic [SEQ_CNT_W-1:0] c_LOAD = SEQ_CNT_W'(DIV_CYCLES - 2);

  seq_state_t             r_state;
  logic [SEQ_CNT_W-1:0]   r_cnt;

  // BUSY lasts c_LOAD cycles: leave it as the counter steps down to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= SEQ_IDLE;
      r_cnt   <= '0;
    end else if (abort) begin
      r_state <= SEQ_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        SEQ_IDLE: begin
          if (start && !hold) begin
            if (c_LOAD == '0) begin
              r_state <= SEQ_DONE;
            end else begin
              r_state <= SEQ_BUSY;
              r_cnt   <= c_LOAD;
            end
          end
        end
        SEQ_BUSY: begin
          if (!hold) begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == SEQ_CNT_W'(1)) begin
              r_state <= SEQ_DONE;
            end
          end
        end
        SEQ_DONE: r_state <= SEQ_IDLE;
        default:  r_state <= SEQ_IDLE;
      endcase
    end
  end

  assign busy     = (r_state == SEQ_BUSY);
  assign done     = (r_state == SEQ_DONE);
  assign seq_hold = ((r_state == SEQ_IDLE) && start) || busy;

endmodule
`default_nettype wire

// File: rtl/musb_hazard_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | musb_hazard_unit: stall/flush/forwarding control for the pipeline.   |
// | MUSB_STALL_CNT_EN adds load-use and mult/div stall cycle counters.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module musb_hazard_unit
  import musb_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic [4:0]  ex_gpr_wa,
  input  logic        ex_gpr_we,
  input  logic        ex_mem_to_gpr_select,
  input  logic [4:0]  mem_gpr_wa,
  input  logic        mem_gpr_we,
  input  logic        mem_mem_to_gpr_select,
  input  logic [4:0]  wb_gpr_wa,
  input  logic        wb_gpr_we,
  input  logic        ex_muldiv_start,
  input  logic        if_mem_busy,
  input  logic        mem_mem_busy,
  input  logic        exc_request,
  output logic [1:0]  forward_id_rs,
  output logic [1:0]  forward_id_rt,
  output logic        if_stall,
  output logic        id_stall,
  output logic        ex_stall,
  output logic        mem_stall,
  output logic        wb_stall,
  output logic        if_flush,
  output logic        id_flush,
  output logic        ex_flush,
  output logic        mem_flush,
`ifdef MUSB_STALL_CNT_EN
  output logic [31:0] perf_load_use_cycles,
  output logic [31:0] perf_muldiv_cycles,
`endif
  output logic        muldiv_busy,
  output logic        muldiv_done
);

  logic w_ex_rs, w_ex_rt, w_mem_rs, w_mem_rt, w_wb_rs, w_wb_rt;
  logic w_flush_now, w_load_use, w_seq_hold, w_seq_hold_eff;
  logic r_exc_pending;

  assign w_ex_rs  = reg_match(id_uses_rs, id_rs, ex_gpr_we,  ex_gpr_wa);
  assign w_ex_rt  = reg_match(id_uses_rt, id_rt, ex_gpr_we,  ex_gpr_wa);
  assign w_mem_rs = reg_match(id_uses_rs, id_rs, mem_gpr_we, mem_gpr_wa);
  assign w_mem_rt = reg_match(id_uses_rt, id_rt, mem_gpr_we, mem_gpr_wa);
  assign w_wb_rs  = reg_match(id_uses_rs, id_rs, wb_gpr_we,  wb_gpr_wa);
  assign w_wb_rt  = reg_match(id_uses_rt, id_rt, wb_gpr_we,  wb_gpr_wa);

  always_comb begin
    forward_id_rs = FWD_GPR;
    if      (w_ex_rs)  forward_id_rs = FWD_EX;
    else if (w_mem_rs) forward_id_rs = FWD_MEM;
    else if (w_wb_rs)  forward_id_rs = FWD_WB;
    forward_id_rt = FWD_GPR;
    if      (w_ex_rt)  forward_id_rt = FWD_EX;
    else if (w_mem_rt) forward_id_rt = FWD_MEM;
    else if (w_wb_rt)  forward_id_rt = FWD_WB;
  end

  // An exception cannot flush while data memory is mid-transfer; it waits.
  assign w_flush_now = (exc_request | r_exc_pending) & ~mem_mem_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_exc_pending <= 1'b0;
    end else if (w_flush_now) begin
      r_exc_pending <= 1'b0;
    end else if (exc_request && mem_mem_busy) begin
      r_exc_pending <= 1'b1;
    end
  end

  assign w_load_use = (((w_ex_rs | w_ex_rt) & ex_mem_to_gpr_select) |
                       ((w_mem_rs | w_mem_rt) & mem_mem_to_gpr_select)) & ~w_flush_now;

  musb_muldiv_sequencer #(
    .DIV_CYCLES (DIV_CYCLES)
  ) u_seq (
    .clk      (clk),
    .rst      (rst),
    .start    (ex_muldiv_start),
    .hold     (mem_mem_busy),
    .abort    (w_flush_now),
    .busy     (muldiv_busy),
    .done     (muldiv_done),
    .seq_hold (w_seq_hold)
  );

  assign w_seq_hold_eff = w_seq_hold & ~w_flush_now;

  // Reset forces every control output low even though the cascade is combinational.
  assign wb_stall  = 1'b0;
  assign mem_stall = rst & mem_mem_busy;
  assign ex_stall  = mem_stall | (rst & w_seq_hold_eff);
  assign id_stall  = ex_stall  | (rst & w_load_use);
  assign if_stall  = id_stall  | (rst & if_mem_busy);

  assign if_flush  = rst & w_flush_now;
  assign id_flush  = rst & w_flush_now;
  assign ex_flush  = rst & w_flush_now;
  assign mem_flush = rst & w_flush_now;

`ifdef MUSB_STALL_CNT_EN
  logic [31:0] r_perf_load_use;
  logic [31:0] r_perf_muldiv;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_load_use <= '0;
      r_perf_muldiv   <= '0;
    end else begin
      if (w_load_use)     r_perf_load_use <= r_perf_load_use + 32'd1;
      if (w_seq_hold_eff) r_perf_muldiv   <= r_perf_muldiv + 32'd1;
    end
  end

  assign perf_load_use_cycles = r_perf_load_use;
  assign perf_muldiv_cycles   = r_perf_muldiv;
`endif

endmodule
`default_nettype wire

// File: tb/tb_musb_hazard_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_musb_hazard_unit: directed self-checking bench, DIV_CYCLES = 4    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_musb_hazard_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  id_rs, id_rt, ex_gpr_wa, mem_gpr_wa, wb_gpr_wa;
  logic        id_uses_rs, id_uses_rt, ex_gpr_we, ex_mem_to_gpr_select;
  logic        mem_gpr_we, mem_mem_to_gpr_select, wb_gpr_we;
  logic        ex_muldiv_start, if_mem_busy, mem_mem_busy, exc_request;
  logic [1:0]  forward_id_rs, forward_id_rt;
  logic        if_stall, id_stall, ex_stall, mem_stall, wb_stall;
  logic        if_flush, id_flush, ex_flush, mem_flush;
  logic        muldiv_busy, muldiv_done;
`ifdef MUSB_STALL_CNT_EN
  logic [31:0] perf_load_use_cycles, perf_muldiv_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  musb_hazard_unit #(.DIV_CYCLES(4)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .id_rs                 (id_rs),
    .id_rt                 (id_rt),
    .id_uses_rs            (id_uses_rs),
    .id_uses_rt            (id_uses_rt),
    .ex_gpr_wa             (ex_gpr_wa),
    .ex_gpr_we             (ex_gpr_we),
    .ex_mem_to_gpr_select  (ex_mem_to_gpr_select),
    .mem_gpr_wa            (mem_gpr_wa),
    .mem_gpr_we            (mem_gpr_we),
    .mem_mem_to_gpr_select (mem_mem_to_gpr_select),
    .wb_gpr_wa             (wb_gpr_wa),
    .wb_gpr_we             (wb_gpr_we),
    .ex_muldiv_start       (ex_muldiv_start),
    .if_mem_busy           (if_mem_busy),
    .mem_mem_busy          (mem_mem_busy),
    .exc_request           (exc_request),
    .forward_id_rs         (forward_id_rs),
    .forward_id_rt         (forward_id_rt),
    .if_stall              (if_stall),
    .id_stall              (id_stall),
    .ex_stall              (ex_stall),
    .mem_stall             (mem_stall),
    .wb_stall              (wb_stall),
    .if_flush              (if_flush),
    .id_flush              (id_flush),
    .ex_flush              (ex_flush),
    .mem_flush             (mem_flush),
`ifdef MUSB_STALL_CNT_EN
    .perf_load_use_cycles  (perf_load_use_cycles),
    .perf_muldiv_cycles    (perf_muldiv_cycles),
`endif
    .muldiv_busy           (muldiv_busy),
    .muldiv_done           (muldiv_done)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clr();
    id_rs = '0; id_rt = '0; id_uses_rs = 0; id_uses_rt = 0;
    ex_gpr_wa = '0; ex_gpr_we = 0; ex_mem_to_gpr_select = 0;
    mem_gpr_wa = '0; mem_gpr_we = 0; mem_mem_to_gpr_select = 0;
    wb_gpr_wa = '0; wb_gpr_we = 0;
    ex_muldiv_start = 0; if_mem_busy = 0; mem_mem_busy = 0; exc_request = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packs {if,id,ex,mem,wb} stalls and {if,id,ex,mem} flushes for compact checks.
  function automatic logic [4:0] stalls();
    return {if_stall, id_stall, ex_stall, mem_stall, wb_stall};
  endfunction
  function automatic logic [3:0] flushes();
    return {if_flush, id_flush, ex_flush, mem_flush};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    #3;
    chk("rst_stalls", 32'(stalls()), 32'h0);
    chk("rst_flush",  32'(flushes()), 32'h0);
    chk("rst_busy",   32'({muldiv_busy, muldiv_done}), 32'h0);
    #9 rst = 1'b1;
    tick();

    // Forwarding
    id_rs = 5'd5; id_uses_rs = 1; ex_gpr_wa = 5'd5; ex_gpr_we = 1; #1;
    chk("fwd_ex", 32'(forward_id_rs), 32'd1);
    chk("fwd_ex_nostall", 32'(id_stall), 32'd0);
    mem_gpr_wa = 5'd5; mem_gpr_we = 1; #1;
    chk("fwd_prio_ex", 32'(forward_id_rs), 32'd1);
    ex_gpr_we = 0; #1;
    chk("fwd_mem", 32'(forward_id_rs), 32'd2);
    wb_gpr_wa = 5'd5; wb_gpr_we = 1; #1;
    chk("fwd_prio_mem", 32'(forward_id_rs), 32'd2);
    mem_gpr_we = 0; #1;
    chk("fwd_wb", 32'(forward_id_rs), 32'd3);
    id_uses_rs = 0; #1;
    chk("fwd_unused", 32'(forward_id_rs), 32'd0);
    clr();
    ex_gpr_we = 1; mem_gpr_we = 1; wb_gpr_we = 1; id_uses_rs = 1; ex_mem_to_gpr_select = 1; #1;
    chk("fwd_r0", 32'(forward_id_rs), 32'd0);
    chk("r0_nostall", 32'(id_stall), 32'd0);
    clr();
    id_rt = 5'd9; id_uses_rt = 1; ex_gpr_wa = 5'd9; ex_gpr_we = 1; #1;
    chk("fwd_rt_ex", 32'(forward_id_rt), 32'd1);

    // Stall cascade from memories
    clr(); if_mem_busy = 1; #1;
    chk("if_busy", 32'(stalls()), 32'b10000);
    clr(); mem_mem_busy = 1; #1;
    chk("mem_busy", 32'(stalls()), 32'b11110);

    // Load-use
    clr(); tick();
    id_rt = 5'd7; id_uses_rt = 1; ex_gpr_wa = 5'd7; ex_gpr_we = 1; ex_mem_to_gpr_select = 1; #1;
    chk("lu_ex_stalls", 32'(stalls()), 32'b11000);
    chk("lu_ex_fwd", 32'(forward_id_rt), 32'd1);
    tick();
    ex_gpr_we = 0; ex_mem_to_gpr_select = 0;
    mem_gpr_wa = 5'd7; mem_gpr_we = 1; mem_mem_to_gpr_select = 1; #1;
    chk("lu_mem_stall", 32'(id_stall), 32'd1);
    chk("lu_mem_fwd", 32'(forward_id_rt), 32'd2);
    tick();
    mem_gpr_we = 0; mem_mem_to_gpr_select = 0; wb_gpr_wa = 5'd7; wb_gpr_we = 1; #1;
    chk("lu_wb_stalls", 32'(stalls()), 32'b00000);
    chk("lu_wb_fwd", 32'(forward_id_rt), 32'd3);
    clr();
    id_rs = 5'd3; id_uses_rs = 1; ex_gpr_wa = 5'd3; ex_gpr_we = 1; ex_mem_to_gpr_select = 1; exc_request = 1; #1;
    chk("lu_flush_override", 32'(id_stall), 32'd0);
    chk("lu_flush", 32'(flushes()), 32'hF);
    clr(); tick();

    // Mult/div, no interference
    ex_muldiv_start = 1; #1;
    chk("md_c1", 32'({ex_stall, muldiv_busy, muldiv_done}), 32'b100);
    tick(); ex_muldiv_start = 0; #1;
    chk("md_c2", 32'({ex_stall, muldiv_busy, muldiv_done}), 32'b110);
    tick();
    chk("md_c3", 32'({ex_stall, muldiv_busy, muldiv_done}), 32'b110);
    tick();
    chk("md_c4", 32'({ex_stall, muldiv_busy, muldiv_done}), 32'b001);
    tick();
    chk("md_c5", 32'({ex_stall, muldiv_busy, muldiv_done}), 32'b000);

    // Mult/div delayed by two data-memory stall cycles
    tick(); ex_muldiv_start = 1; #1;
    tick(); ex_muldiv_start = 0; mem_mem_busy = 1; #1;
    chk("mdh_c2", 32'({ex_stall, muldiv_busy, muldiv_done}), 32'b110);
    tick();
    chk("mdh_c3", 32'({ex_stall, muldiv_busy, muldiv_done}), 32'b110);
    tick(); mem_mem_busy = 0; #1;
    chk("mdh_c4", 32'({ex_stall, muldiv_busy, muldiv_done}), 32'b110);
    tick();
    chk("mdh_c5", 32'({ex_stall, muldiv_busy, muldiv_done}), 32'b110);
    tick();
    chk("mdh_c6", 32'({ex_stall, muldiv_busy, muldiv_done}), 32'b001);
    tick();
    chk("mdh_c7", 32'({muldiv_busy, muldiv_done}), 32'b00);

    // Exception held pending across three busy cycles, second request absorbed
    clr(); tick();
    mem_mem_busy = 1; exc_request = 1; #1;
    chk("exc_c1", 32'(flushes()), 32'h0);
    tick(); exc_request = 0; #1;
    chk("exc_c2", 32'(flushes()), 32'h0);
    tick(); exc_request = 1; #1;
    chk("exc_c3", 32'(flushes()), 32'h0);
    tick(); exc_request = 0; mem_mem_busy = 0; #1;
    chk("exc_c4", 32'(flushes()), 32'hF);
    tick();
    chk("exc_c5", 32'(flushes()), 32'h0);
    tick();
    chk("exc_c6", 32'(flushes()), 32'h0);

    // Abort during BUSY
    ex_muldiv_start = 1; #1;
    tick(); ex_muldiv_start = 0; #1;
    chk("abort_busy", 32'(muldiv_busy), 32'd1);
    exc_request = 1; #1;
    chk("abort_now", 32'({ex_stall, ex_flush}), 32'b01);
    tick(); exc_request = 0; #1;
    chk("abort_c1", 32'({ex_stall, muldiv_busy, muldiv_done}), 32'b000);
    tick();
    chk("abort_c2", 32'({ex_stall, muldiv_busy, muldiv_done}), 32'b000);
    tick();
    chk("abort_c3", 32'(muldiv_done), 32'd0);

    // Reset during BUSY with an exception pending
    ex_muldiv_start = 1; #1;
    tick(); ex_muldiv_start = 0; mem_mem_busy = 1; exc_request = 1; #1;
    tick(); exc_request = 0; #1;
    chk("prereset_busy", 32'(muldiv_busy), 32'd1);
    rst = 1'b0; #1;
    chk("areset_stalls", 32'(stalls()), 32'h0);
    chk("areset_md", 32'({muldiv_busy, muldiv_done}), 32'h0);
    chk("areset_flush", 32'(flushes()), 32'h0);
    clr(); #1;
    rst = 1'b1;
    tick();
    chk("post_reset_flush", 32'(flushes()), 32'h0);
    chk("post_reset_md", 32'({muldiv_busy, muldiv_done}), 32'h0);
    tick();
    chk("post_reset_flush2", 32'(flushes()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/musb_hazard_unit.md
Name: musb_hazard_unit

Overview:
- Pipeline controller that sequences the ID->EX pipeline register and its neighbours.
- Generates per-stage stall and flush signals and the ID-stage forwarding selects for Rs/Rt.
- Runs a multi-cycle mult/div sequencer that holds EX, and holds exception flushes pending while data memory is busy.
- Sits beside the datapath; drives id_stall, ex_stall and id_flush of the ID->EX register.

Parameters:
DIV_CYCLES, 32, total EX occupancy in cycles of a mult/div op (legal range 2..63)

Ports:
clk  input  1  main clock
rst  input  1  asynchronous, active-low reset
id_rs  input  5  Rs of instruction in ID
id_rt  input  5  Rt of instruction in ID
id_uses_rs  input  1  ID instruction reads Rs
id_uses_rt  input  1  ID instruction reads Rt
ex_gpr_wa  input  5  destination register in EX
ex_gpr_we  input  1  EX writes GPR
ex_mem_to_gpr_select  input  1  EX instruction is a load
mem_gpr_wa  input  5  destination register in MEM
mem_gpr_we  input  1  MEM writes GPR
mem_mem_to_gpr_select  input  1  MEM instruction is a load
wb_gpr_wa  input  5  destination register in WB
wb_gpr_we  input  1  WB writes GPR
ex_muldiv_start  input  1  mult/div operation present in EX
if_mem_busy  input  1  instruction memory not ready
mem_mem_busy  input  1  data memory not ready
exc_request  input  1  exception detected (single-cycle pulse)
forward_id_rs  output  2  Rs source: 0 GPR, 1 EX result, 2 MEM result, 3 WB result
forward_id_rt  output  2  Rt source, same encoding
if_stall, id_stall, ex_stall, mem_stall, wb_stall  output  1 each  stage hold
if_flush, id_flush, ex_flush, mem_flush  output  1 each  stage clear
muldiv_busy  output  1  sequencer in BUSY
muldiv_done  output  1  one-cycle pulse, last cycle of an operation

Behaviour:
- Reset (rst=0, async): FSM IDLE, counter 0, exc_pending 0; every stall, flush and muldiv output 0; forwarding selects are combinational.
- Register 0 never matches: there is no forwarding and no hazard on $0.
- Forwarding, per operand, only when the uses_* bit is set. Priority is EX > MEM > WB; a match requires we=1 and wa==reg.
- Load-use stall: an EX match with ex_mem_to_gpr_select=1, or a MEM match with mem_mem_to_gpr_select=1, asserts id_stall.
- Stall cascade, combinational: wb_stall=0; mem_stall=mem_mem_busy; ex_stall=mem_stall | seq_hold; id_stall=ex_stall | load_use; if_stall=id_stall | if_mem_busy.
- Sequencer FSM, states IDLE, BUSY, DONE:
  - IDLE->BUSY when ex_muldiv_start & !mem_stall & !flush_now; counter loads DIV_CYCLES-2.
  - BUSY: decrement while !mem_stall; when counter==0 -> DONE.
  - DONE: muldiv_done=1 for one cycle, then -> IDLE; a start seen in DONE is ignored.
  - seq_hold=1 in IDLE-with-start and in BUSY, so EX occupancy is exactly DIV_CYCLES cycles absent mem stalls.
  - muldiv_busy=1 only in BUSY.
- Exception flush:
  - flush_now = (exc_request | exc_pending) & !mem_mem_busy.
  - exc_request while mem_mem_busy sets exc_pending; exc_pending clears when flush_now fires.
  - flush_now asserts if_flush, id_flush, ex_flush and mem_flush for one cycle, aborts the FSM to IDLE, and overrides load_use and seq_hold.
  - A second exc_request while pending is absorbed (single flush).
- Reset mid-operation returns everything to reset values immediately; no pending state survives.

Optional Feature:
- MUSB_STALL_CNT_EN defined: adds outputs perf_load_use_cycles [31:0] and perf_muldiv_cycles [31:0].
  - Free-running, wrapping counters of cycles with load_use=1 and seq_hold=1 respectively.
  - Reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package musb_pkg:
  - FWD_GPR/FWD_EX/FWD_MEM/FWD_WB 2-bit encodings.
  - SEQ_IDLE/SEQ_BUSY/SEQ_DONE state encodings.
  - Counter width constant (6 bits).
- Sub-module musb_muldiv_sequencer: FSM plus counter; ports are start, hold, abort, busy, done, seq_hold.

Test Plan:
- Forwarding: id_rs=5, id_uses_rs=1; ex wa=5 we=1 non-load -> forward_id_rs=1. Same with ex we=0 and mem wa=5 we=1 -> 2. Rs=0 with any match -> 0.
- Load-use: ex wa=7 load, id_rt=7 uses_rt -> id_stall=1, if_stall=1, ex_stall=0 for exactly one cycle once the load advances to MEM and MEM=load keeps stalling; then forward_id_rt=3 after WB.
- Mult/div: DIV_CYCLES=4, single start pulse -> ex_stall high 3 cycles, muldiv_done pulses in 4th, FSM IDLE in 5th. Inject mem_mem_busy for 2 mid-op cycles -> completion delayed by 2.
- Pending exception: exc_request while mem_mem_busy=1 for 3 cycles -> no flush during busy; all four flushes high exactly one cycle after busy drops; second request during busy -> still one flush.
- Abort: exception during BUSY -> FSM IDLE next cycle, muldiv_done never pulses, ex_stall deasserted.
- Reset: assert rst=0 during BUSY with exc_pending=1 -> all outputs 0 asynchronously; after release, no flush occurs.
